bcd_updown_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_digit.sv | 43 ++++
 rtl/bcd_updown_counter.sv | 46 ++++
 tb/tb_bcd_updown_counter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and the load sanitiser.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_sanitise(input bcd_digit_t digit);
    return (digit > BCD_MAX) ? BCD_MIN : digit;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: sanitised parallel load, single up/down step with 9<->0 wrap.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t d,
  output bcd_digit_t q,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_sanitise(d);
    end else if (step) begin
      if (up) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q      = digit_q;
  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load and cascadable terminal count.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc
);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;

  // Ripple enable: a digit moves only when every lower digit is at its wrap point.
  always_comb begin
    step    = '0;
    step[0] = en & ~load;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      step[i] = step[i-1] & (up ? at_max[i-1] : at_min[i-1]);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .step   (step[g]),
      .up     (up),
      .load   (load),
      .d      (din[4*g +: 4]),
      .q      (q[4*g +: 4]),
      .at_max (at_max[g]),
      .at_min (at_min[g])
    );
  end

  assign tc = en & ~load & (up ? (&at_max) : (&at_min));

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: reset, sweep, wraps, sanitised load, load priority and a two-stage cascade.
module tb_bcd_updown_counter;

  logic       clk;
  logic       rst_n;
  logic       en, up, load;
  logic [7:0] din;
  logic [7:0] q;
  logic       tc;

  logic       c_en, c_load;
  logic [7:0] c_din_lo, c_din_hi;
  logic [7:0] c_q_lo, c_q_hi;
  logic       c_tc_lo, c_tc_hi;

  int n_total = 0;
  int n_bad   = 0;

  bcd_updown_counter #(.DIGITS(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .up    (up),
    .load  (load),
    .din   (din),
    .q     (q),
    .tc    (tc)
  );

  bcd_updown_counter #(.DIGITS(2)) u_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (c_en),
    .up    (1'b1),
    .load  (c_load),
    .din   (c_din_lo),
    .q     (c_q_lo),
    .tc    (c_tc_lo)
  );

  bcd_updown_counter #(.DIGITS(2)) u_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (c_tc_lo),
    .up    (1'b1),
    .load  (c_load),
    .din   (c_din_hi),
    .q     (c_q_hi),
    .tc    (c_tc_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens, ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = 8'h00;
    c_en = 1'b0; c_load = 1'b0; c_din_lo = 8'h00; c_din_hi = 8'h00;
    #2;
    check("reset_q", 16'(q), 16'h0000);
    check("reset_tc", 16'(tc), 16'h0000);
    tick();
    rst_n = 1'b1;

    // Count up to 37, then reset asynchronously between edges.
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 37; i++) tick();
    check("count_to_37", 16'(q), 16'h0037);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 16'(q), 16'h0000);
    tick();
    check("held_in_reset", 16'(q), 16'h0000);
    rst_n = 1'b1;
    tick();
    check("first_after_reset", 16'(q), 16'h0001);

    // Full up sweep from zero, checking q and tc before every edge.
    en = 1'b0; load = 1'b1; din = 8'h00;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      check($sformatf("sweep_q_%0d", k), 16'(q), 16'(to_bcd(k)));
      check($sformatf("sweep_tc_%0d", k), 16'(tc), 16'(k == 99));
      tick();
    end
    check("sweep_wrap", 16'(q), 16'h0000);

    // Down wrap from 01.
    en = 1'b0; load = 1'b1; din = 8'h01;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    check("down_to_00", 16'(q), 16'h0000);
    check("down_tc_at_00", 16'(tc), 16'h0001);
    tick();
    check("down_wrap_99", 16'(q), 16'h0099);
    check("down_tc_at_99", 16'(tc), 16'h0000);

    // Sanitised loads.
    en = 1'b0; load = 1'b1; din = 8'hA5;
    tick();
    check("load_A5", 16'(q), 16'h0005);
    din = 8'h3F;
    tick();
    check("load_3F", 16'(q), 16'h0030);
    din = 8'hCE;
    tick();
    check("load_CE", 16'(q), 16'h0000);

    // Load beats enable, and suppresses tc.
    din = 8'h99;
    tick();
    en = 1'b1; up = 1'b1; load = 1'b1; din = 8'h42;
    #1 check("load_en_tc", 16'(tc), 16'h0000);
    tick();
    check("load_en_q", 16'(q), 16'h0042);

    // Hold, then direction changes each cycle.
    load = 1'b0; en = 1'b0;
    tick();
    check("hold", 16'(q), 16'h0042);
    en = 1'b1; up = 1'b1;
    tick();
    check("step_up", 16'(q), 16'h0043);
    up = 1'b0;
    tick();
    check("step_down", 16'(q), 16'h0042);
    en = 1'b0;

    // Cascade: 0099 -> 0100 in one edge.
    c_load = 1'b1; c_din_lo = 8'h99; c_din_hi = 8'h00;
    tick();
    c_load = 1'b0; c_en = 1'b1;
    #1 check("cascade_tc_lo", 16'(c_tc_lo), 16'h0001);
    tick();
    check("cascade_0100", {c_q_hi, c_q_lo}, 16'h0100);
    check("cascade_tc_lo_after", 16'(c_tc_lo), 16'h0000);
    c_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
